// File: rtl/adam_obi_to_axil_pipe.sv
// rtl/adam_obi_to_axil_pipe.sv - pipelined OBI to AXI-Lite bridge with in-order responses and pause drain
//
// Accepts up to MAX_TRANS outstanding OBI requests, forwards them to AXI-Lite
// and returns responses to OBI in request order.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   pause_req / pause_ack     pause handshake; ack = port idle and blocked
//   req/gnt/addr/we/be/wdata  OBI request channel (gnt combinational)
//   rvalid/rready/rdata/err   OBI response channel (registered)
//   axil_*                    AXI-Lite master channels aw, w, b, ar, r (prot = 0)

module adam_obi_to_axil_pipe #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_TRANS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pause_req,
    output logic                    pause_ack,
    input  logic                    req,
    output logic                    gnt,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    err,
    output logic [ADDR_WIDTH-1:0]   axil_aw_addr,
    output logic [2:0]              axil_aw_prot,
    output logic                    axil_aw_valid,
    input  logic                    axil_aw_ready,
    output logic [DATA_WIDTH-1:0]   axil_w_data,
    output logic [DATA_WIDTH/8-1:0] axil_w_strb,
    output logic                    axil_w_valid,
    input  logic                    axil_w_ready,
    input  logic [1:0]              axil_b_resp,
    input  logic                    axil_b_valid,
    output logic                    axil_b_ready,
    output logic [ADDR_WIDTH-1:0]   axil_ar_addr,
    output logic [2:0]              axil_ar_prot,
    output logic                    axil_ar_valid,
    input  logic                    axil_ar_ready,
    input  logic [DATA_WIDTH-1:0]   axil_r_data,
    input  logic [1:0]              axil_r_resp,
    input  logic                    axil_r_valid,
    output logic                    axil_r_ready
);

    localparam int CW = $clog2(MAX_TRANS + 1);
    localparam int PW = (MAX_TRANS > 1) ? $clog2(MAX_TRANS) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, PAUSED} state_t;

    state_t state, state_next;

    logic [CW-1:0]        count;
    logic [CW-1:0]        fifo_cnt;
    logic [MAX_TRANS-1:0] order_mem;   // 1 = write, 0 = read
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic                 fifo_head;
    logic                 fifo_empty;
    logic                 slot_free;
    logic                 resp_slot_free;
    logic                 b_hs, r_hs, rsp_hs;
    logic                 idle;

    assign axil_aw_prot   = 3'b000;
    assign axil_ar_prot   = 3'b000;

    assign fifo_empty     = (fifo_cnt == '0);
    assign fifo_head      = order_mem[rd_ptr];
    assign resp_slot_free = !rvalid || rready;

    // Only the transaction type at the head of the order FIFO may complete,
    // which is what keeps OBI responses in request order.
    assign axil_b_ready   = resp_slot_free && !fifo_empty && fifo_head;
    assign axil_r_ready   = resp_slot_free && !fifo_empty && !fifo_head;
    assign b_hs           = axil_b_valid && axil_b_ready;
    assign r_hs           = axil_r_valid && axil_r_ready;
    assign rsp_hs         = rvalid && rready;

    assign idle = (count == '0) && !axil_aw_valid && !axil_w_valid && !axil_ar_valid;

    always_comb begin
        state_next = state;
        slot_free  = we ? (!axil_aw_valid && !axil_w_valid) : !axil_ar_valid;
        gnt        = req && (state == RUN) && !pause_req &&
                     (count < CW'(MAX_TRANS)) && slot_free;
        case (state)
            RUN:     if (pause_req) state_next = DRAIN;
            DRAIN: begin
                if (!pause_req)  state_next = RUN;
                else if (idle)   state_next = PAUSED;
            end
            PAUSED:  if (!pause_req) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            pause_ack     <= 1'b0;
            count         <= '0;
            fifo_cnt      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            axil_aw_valid <= 1'b0;
            axil_w_valid  <= 1'b0;
            axil_ar_valid <= 1'b0;
            rvalid        <= 1'b0;
        end else begin
            state     <= state_next;
            pause_ack <= (state_next == PAUSED);

            if (gnt && we) begin
                axil_aw_valid <= 1'b1;
                axil_w_valid  <= 1'b1;
            end else begin
                if (axil_aw_ready) axil_aw_valid <= 1'b0;
                if (axil_w_ready)  axil_w_valid  <= 1'b0;
            end
            if (gnt && !we)         axil_ar_valid <= 1'b1;
            else if (axil_ar_ready) axil_ar_valid <= 1'b0;

            if (gnt) begin
                order_mem[wr_ptr] <= we;
                wr_ptr <= (wr_ptr == PW'(MAX_TRANS - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (b_hs || r_hs) begin
                rd_ptr <= (rd_ptr == PW'(MAX_TRANS - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({gnt, b_hs || r_hs})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase

            // A transaction stays counted until OBI accepts its response.
            case ({gnt, rsp_hs})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (b_hs || r_hs)  rvalid <= 1'b1;
            else if (rready)   rvalid <= 1'b0;
        end
    end

    // Payload and response data need no reset; they are qualified by valids.
    always_ff @(posedge clk) begin
        if (gnt && we) begin
            axil_aw_addr <= addr;
            axil_w_data  <= wdata;
            axil_w_strb  <= be;
        end
        if (gnt && !we) axil_ar_addr <= addr;
        if (r_hs) begin
            rdata <= axil_r_data;
            err   <= (axil_r_resp != 2'b00);
        end else if (b_hs) begin
            rdata <= '0;
            err   <= (axil_b_resp != 2'b00);
        end
    end

endmodule

// File: tb/tb_adam_obi_to_axil_pipe.sv
// tb/tb_adam_obi_to_axil_pipe.sv - self-checking bench for adam_obi_to_axil_pipe

module tb_adam_obi_to_axil_pipe;

    logic        clk = 1'b0;
    logic        rst, pause_req, pause_ack, req, gnt, we, rvalid, rready, err;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
    logic [31:0] aw_addr, w_data, ar_addr, r_data;
    logic [2:0]  aw_prot, ar_prot;
    logic [3:0]  w_strb;
    logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic        ar_valid, ar_ready, r_valid, r_ready;
    logic [1:0]  b_resp, r_resp;

    always #5 clk = ~clk;

    adam_obi_to_axil_pipe #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_TRANS(4)) dut (
        .clk(clk), .rst(rst), .pause_req(pause_req), .pause_ack(pause_ack),
        .req(req), .gnt(gnt), .addr(addr), .we(we), .be(be), .wdata(wdata),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .err(err),
        .axil_aw_addr(aw_addr), .axil_aw_prot(aw_prot), .axil_aw_valid(aw_valid),
        .axil_aw_ready(aw_ready), .axil_w_data(w_data), .axil_w_strb(w_strb),
        .axil_w_valid(w_valid), .axil_w_ready(w_ready), .axil_b_resp(b_resp),
        .axil_b_valid(b_valid), .axil_b_ready(b_ready), .axil_ar_addr(ar_addr),
        .axil_ar_prot(ar_prot), .axil_ar_valid(ar_valid), .axil_ar_ready(ar_ready),
        .axil_r_data(r_data), .axil_r_resp(r_resp), .axil_r_valid(r_valid),
        .axil_r_ready(r_ready)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct packed { logic [31:0] rdata; logic err; } rsp_t;
    typedef struct packed { logic [31:0] data; logic [1:0] resp; } axr_t;
    typedef struct packed { logic [31:0] data; logic [3:0] strb; } wd_t;

    int checks = 0;
    int errors = 0;
    logic        rnd = 1'b0;
    logic        stall_r, stall_b;
    logic [31:0] cur_exp_rdata;
    logic        cur_exp_err;

    rsp_t        sb[$];
    logic [31:0] ar_exp[$], aw_exp[$];
    wd_t         w_exp[$];

    logic [31:0] mem [logic [31:0]];
    axr_t        rq[$];
    logic [1:0]  bq[$];
    logic [31:0] awq[$];
    wd_t         wq[$];
    logic        s_ar, s_aw, s_w, s_r, s_b;
    logic [31:0] s_ar_addr, s_aw_addr;
    wd_t         s_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Slave memory model: regions 0xE/0xD answer SLVERR/DECERR with zero data.
    function automatic axr_t rd_model(input logic [31:0] a);
        axr_t x;
        if (a[31:28] == 4'hE)      x = '{data: 32'h0, resp: 2'b10};
        else if (a[31:28] == 4'hD) x = '{data: 32'h0, resp: 2'b11};
        else if (mem.exists(a))    x = '{data: mem[a], resp: 2'b00};
        else                       x = '{data: ~a, resp: 2'b00};
        return x;
    endfunction

    // Negedge: OBI/AXI monitors and sampling of handshakes for the slave.
    always @(negedge clk) begin
        s_ar = 0; s_aw = 0; s_w = 0; s_r = 0; s_b = 0;
        if (rst) begin
            sb.delete(); ar_exp.delete(); aw_exp.delete(); w_exp.delete();
        end else begin
            if (req && gnt) begin
                sb.push_back('{rdata: cur_exp_rdata, err: cur_exp_err});
                if (we) begin
                    aw_exp.push_back(addr);
                    w_exp.push_back('{data: wdata, strb: be});
                end else begin
                    ar_exp.push_back(addr);
                end
            end
            if (ar_valid && ar_ready) begin
                s_ar = 1; s_ar_addr = ar_addr;
                if (ar_exp.size() == 0) chk("ar_unexpected", 32'h1, 32'h0);
                else chk("ar_addr", ar_addr, ar_exp.pop_front());
            end
            if (aw_valid && aw_ready) begin
                s_aw = 1; s_aw_addr = aw_addr;
                if (aw_exp.size() == 0) chk("aw_unexpected", 32'h1, 32'h0);
                else chk("aw_addr", aw_addr, aw_exp.pop_front());
            end
            if (w_valid && w_ready) begin
                s_w = 1; s_wd = '{data: w_data, strb: w_strb};
                if (w_exp.size() == 0) chk("w_unexpected", 32'h1, 32'h0);
                else chk("w_data_strb", {w_data, 28'h0, w_strb}, {w_exp[0].data, 28'h0, w_exp[0].strb});
                if (w_exp.size() != 0) void'(w_exp.pop_front());
            end
            s_r = r_valid && r_ready;
            s_b = b_valid && b_ready;
            if (rvalid && rready) begin
                if (sb.size() == 0) chk("rsp_unexpected", 32'h1, 32'h0);
                else begin
                    chk("rsp_rdata", rdata, sb[0].rdata);
                    chk("rsp_err", {31'h0, err}, {31'h0, sb[0].err});
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Slave: applies handshakes sampled at the preceding negedge.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            rq.delete(); bq.delete(); awq.delete(); wq.delete();
        end else begin
            if (s_r && rq.size() != 0) void'(rq.pop_front());
            if (s_b && bq.size() != 0) void'(bq.pop_front());
            if (s_aw) awq.push_back(s_aw_addr);
            if (s_w)  wq.push_back(s_wd);
            while (awq.size() != 0 && wq.size() != 0) begin
                logic [31:0] a, old;
                wd_t d;
                a = awq.pop_front();
                d = wq.pop_front();
                if (a[31:28] == 4'hE)      bq.push_back(2'b10);
                else if (a[31:28] == 4'hD) bq.push_back(2'b11);
                else begin
                    old = mem.exists(a) ? mem[a] : ~a;
                    for (int i = 0; i < 4; i++)
                        if (d.strb[i]) old[i*8 +: 8] = d.data[i*8 +: 8];
                    mem[a] = old;
                    bq.push_back(2'b00);
                end
            end
            if (s_ar) rq.push_back(rd_model(s_ar_addr));
        end
        r_valid = (rq.size() != 0) && !stall_r;
        r_data  = (rq.size() != 0) ? rq[0].data : 32'h0;
        r_resp  = (rq.size() != 0) ? rq[0].resp : 2'b00;
        b_valid = (bq.size() != 0) && !stall_b;
        b_resp  = (bq.size() != 0) ? bq[0] : 2'b00;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rnd) begin
            rready  = ($urandom_range(0, 3) != 0);
            stall_r = ($urandom_range(0, 2) == 0);
            stall_b = ($urandom_range(0, 2) == 0);
        end
    endtask

    task automatic issue(input vec_t v);
        int  n;
        logic got;
        req = 1; we = v.we; addr = v.addr; wdata = v.wdata; be = v.be;
        cur_exp_rdata = v.exp_rdata; cur_exp_err = v.exp_err;
        n = 0; got = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            got = gnt;
            cyc();
            n++;
        end
        req = 0;
        chk("issue_granted", {31'h0, got}, 32'h1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            cyc();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d responses outstanding, expected 0", name, sb.size());
        end
    endtask

    function automatic vec_t rv(input logic [31:0] a, input logic [31:0] d, input logic e);
        vec_t v = '{1'b0, a, 32'h0, 4'h0, d, e};
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        int   grants, hs, bad;
        logic seen, acked;

        tbl[0] = '{1'b0, 32'h0000_0100, 32'h0,         4'h0,    32'hDEAD_BEEF, 1'b0};
        tbl[1] = '{1'b1, 32'h0000_0200, 32'h1122_3344, 4'hF,    32'h0,         1'b0};
        tbl[2] = '{1'b0, 32'h0000_0200, 32'h0,         4'h0,    32'h1122_3344, 1'b0};
        tbl[3] = '{1'b1, 32'h0000_0200, 32'hAABB_CCDD, 4'b0101, 32'h0,         1'b0};
        tbl[4] = '{1'b0, 32'h0000_0200, 32'h0,         4'h0,    32'h11BB_33DD, 1'b0};
        tbl[5] = '{1'b0, 32'hE000_0010, 32'h0,         4'h0,    32'h0,         1'b1};
        tbl[6] = '{1'b0, 32'h0000_0300, 32'h0,         4'h0,    32'hFFFF_FCFF, 1'b0};
        tbl[7] = '{1'b0, 32'hD000_0000, 32'h0,         4'h0,    32'h0,         1'b1};
        tbl[8] = '{1'b1, 32'hE000_0004, 32'h5555_AAAA, 4'hF,    32'h0,         1'b1};
        tbl[9] = '{1'b0, 32'h0000_0104, 32'h0,         4'h0,    32'hFFFF_FEFB, 1'b0};

        rst = 1; pause_req = 0; req = 0; we = 0; addr = 0; wdata = 0; be = 0;
        rready = 1; stall_r = 0; stall_b = 0;
        aw_ready = 1; w_ready = 1; ar_ready = 1;
        r_valid = 0; r_data = 0; r_resp = 0; b_valid = 0; b_resp = 0;
        cur_exp_rdata = 0; cur_exp_err = 0;
        mem[32'h100] = 32'hDEAD_BEEF;
        repeat (3) cyc();

        @(negedge clk);
        chk("rst_aw_valid", {31'h0, aw_valid}, 32'h0);
        chk("rst_w_valid", {31'h0, w_valid}, 32'h0);
        chk("rst_ar_valid", {31'h0, ar_valid}, 32'h0);
        chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
        chk("rst_pause_ack", {31'h0, pause_ack}, 32'h0);

        // First read: grant cycle 0, ar cycle 1, rvalid cycle 3 with a 1-cycle slave.
        cyc();
        rst = 0; req = 1; we = 0; addr = 32'h100;
        cur_exp_rdata = 32'hDEAD_BEEF; cur_exp_err = 0;
        @(negedge clk); chk("first_gnt", {31'h0, gnt}, 32'h1);
        cyc(); req = 0;
        @(negedge clk); chk("first_ar_valid", {31'h0, ar_valid}, 32'h1);
        chk("first_ar_addr", ar_addr, 32'h100);
        cyc(); @(negedge clk); chk("first_rvalid_c2", {31'h0, rvalid}, 32'h0);
        cyc(); @(negedge clk); chk("first_rvalid_c3", {31'h0, rvalid}, 32'h1);
        cyc();

        for (int i = 0; i < 10; i++) issue(tbl[i]);
        drain("table_pass");
        rnd = 1;
        for (int i = 0; i < 10; i++) issue(tbl[i]);
        drain("table_random_pass");
        rnd = 0; rready = 1; stall_r = 0; stall_b = 0;
        cyc();

        // AW and W complete independently.
        w_ready = 0;
        issue('{1'b1, 32'h500, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0});
        @(negedge clk);
        chk("aww_both_valid", {30'h0, aw_valid, w_valid}, 32'h3);
        cyc(); @(negedge clk);
        chk("aww_aw_dropped", {30'h0, aw_valid, w_valid}, 32'h1);
        chk("aww_w_held", w_data, 32'hCAFE_F00D);
        cyc(); w_ready = 1;
        drain("aw_w_indep");

        // Outstanding limit: 6 reads requested, responses stalled.
        stall_r = 1; req = 1; we = 0; addr = 32'h300;
        cur_exp_rdata = 32'hFFFF_FCFF; cur_exp_err = 0;
        grants = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); if (gnt) grants++;
            cyc();
        end
        chk("limit_grants", grants, 4);
        stall_r = 0; seen = 0; bad = 0;
        for (int i = 0; i < 60 && grants < 6; i++) begin
            @(negedge clk);
            if (gnt) begin
                if (!seen) bad++;
                grants++;
            end
            if (rvalid && rready) seen = 1;
            cyc();
        end
        req = 0;
        chk("limit_grant_after_rsp", bad, 0);
        chk("limit_total_grants", grants, 6);
        drain("limit");

        // Ordering: R ready before B, must wait for B.
        stall_b = 1;
        issue('{1'b1, 32'h400, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0});
        issue(rv(32'h100, 32'hDEAD_BEEF, 1'b0));
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if ((r_valid && r_ready) || rvalid) bad++;
            cyc();
        end
        chk("order_r_backpressured", bad, 0);
        chk("order_r_presented", {31'h0, r_valid}, 32'h1);
        stall_b = 0;
        drain("ordering");

        // Pause from idle: ack two cycles after req.
        cyc(); pause_req = 1;
        @(negedge clk); chk("pidle_ack_c0", {31'h0, pause_ack}, 32'h0);
        cyc(); @(negedge clk); chk("pidle_ack_c1", {31'h0, pause_ack}, 32'h0);
        cyc(); @(negedge clk); chk("pidle_ack_c2", {31'h0, pause_ack}, 32'h1);
        cyc(); pause_req = 0;
        @(negedge clk); chk("pidle_ack_c3", {31'h0, pause_ack}, 32'h1);
        cyc(); @(negedge clk); chk("pidle_ack_c4", {31'h0, pause_ack}, 32'h0);
        cyc();

        // Pause with 3 reads in flight.
        stall_r = 1;
        for (int i = 0; i < 3; i++) issue(rv(32'h100, 32'hDEAD_BEEF, 1'b0));
        cyc();
        req = 1; we = 0; addr = 32'h104; cur_exp_rdata = 32'hFFFF_FEFB; cur_exp_err = 0;
        pause_req = 1;
        @(negedge clk); chk("pause_gnt_blocked", {31'h0, gnt}, 32'h0);
        cyc(); stall_r = 0;
        hs = 0; bad = 0; acked = 0;
        for (int i = 0; i < 40 && !acked; i++) begin
            @(negedge clk);
            if (pause_ack) begin
                acked = 1;
                if (hs < 3) bad++;
            end
            if (gnt) bad++;
            if (rvalid && rready) hs++;
            if (!acked) cyc();
        end
        chk("pause_drain_ok", bad, 0);
        chk("pause_acked", {31'h0, acked}, 32'h1);
        cyc(); pause_req = 0;
        @(negedge clk); chk("pause_still_blocked", {30'h0, pause_ack, gnt}, 32'h2);
        cyc(); @(negedge clk); chk("pause_resume", {30'h0, pause_ack, gnt}, 32'h1);
        cyc(); req = 0;
        drain("pause");

        // Reset mid-operation with a write stuck on AW.
        aw_ready = 0;
        issue('{1'b1, 32'h600, 32'h1234_5678, 4'hF, 32'h0, 1'b0});
        req = 1; we = 1; addr = 32'h604;
        @(negedge clk); chk("mid_second_write_blocked", {31'h0, gnt}, 32'h0);
        cyc(); @(negedge clk); chk("mid_aw_pending", {31'h0, aw_valid}, 32'h1);
        cyc(); req = 0; rst = 1;
        cyc(); rst = 0; aw_ready = 1;
        req = 1; we = 0; addr = 32'h300; cur_exp_rdata = 32'hFFFF_FCFF; cur_exp_err = 0;
        @(negedge clk);
        chk("mid_rst_valids", {28'h0, aw_valid, w_valid, ar_valid, rvalid}, 32'h0);
        chk("mid_rst_ack", {31'h0, pause_ack}, 32'h0);
        chk("mid_rst_gnt", {31'h0, gnt}, 32'h1);
        cyc(); req = 0;
        drain("reset_mid");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
